// File: rtl/uart_rx_os4.sv
// 4x-oversampling UART receiver with optional parity, a one-entry valid/ready
// holding register and single-cycle framing/parity/overrun error pulses.
module uart_rx_os4 #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baudtick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    logic [1:0]           sync_q;
    state_t               state_q;
    logic [1:0]           tick_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 pmis_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 framing_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;
    logic                 busy_q;

    logic rx_s;
    logic accept;
    logic can_load;

    assign rx_s     = sync_q[1];
    assign accept   = rx_valid_q & rx_ready;
    // A new word may enter the holding register if it is empty or being drained now.
    assign can_load = ~rx_valid_q | rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tick_q        <= 2'd0;
            idx_q         <= '0;
            shift_q       <= '0;
            pmis_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_q     <= 1'b0;
            if (accept) begin
                rx_valid_q <= 1'b0;
            end
            if (baudtick) begin
                tick_q <= tick_q + 2'd1;
                unique case (state_q)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state_q <= S_START;
                            tick_q  <= 2'd0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_START: begin
                        // Second tick after entry is the middle of the start bit.
                        if (tick_q == 2'd1) begin
                            tick_q <= 2'd0;
                            if (rx_s) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_DATA;
                                idx_q   <= '0;
                                pmis_q  <= 1'b0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (tick_q == 2'd3) begin
                            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                            idx_q   <= idx_q + IW'(1);
                            if (idx_q == LAST_IDX) begin
                                state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (tick_q == 2'd3) begin
                            pmis_q  <= ((^shift_q) ^ rx_s) != logic'(PARITY == 2);
                            state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (tick_q == 2'd3) begin
                            if (!rx_s) begin
                                framing_err_q <= 1'b1;
                                state_q       <= S_BRK;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                if (pmis_q) begin
                                    parity_err_q <= 1'b1;
                                end else if (can_load) begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end
                    end
                    S_BRK: begin
                        // Wait for the line to recover so a break is not seen as a start.
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign parity_err  = parity_err_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_os4.sv
// Scoreboard bench for uart_rx_os4: three receivers (no/even/odd parity) share one
// tick; frames are modelled from the line protocol and checked by per-unit monitors.
module tb_uart_rx_os4;

    localparam int DB     = 8;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;
    localparam int K_OVR  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          baudtick = 1'b0;
    logic          rx   [3];
    logic          rdy  [3];
    logic [DB-1:0] rdata[3];
    logic          rvld [3];
    logic          ferr [3];
    logic          perr [3];
    logic          ovr  [3];
    logic          busy [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dq[3][$];
    int eq[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Tick on every 4th rising edge: edges whose index is a multiple of 4.
    always @(negedge clk) baudtick <= ((cyc + 1) % 4 == 0);

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_err(int u, int k, string nm);
        int got;
        got = (eq[u].size() != 0) ? eq[u].pop_front() : 0;
        total++;
        if (got != k) begin
            bad++;
            $display("FAIL %s u%0d: pulse kind=%0d seen, expected kind=%0d", nm, u, k, got);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gu
        int e;
        uart_rx_os4 #(.DATA_BITS(DB), .PARITY(g)) dut (
            .clk        (clk),
            .rst        (rst),
            .baudtick   (baudtick),
            .rx         (rx[g]),
            .rx_data    (rdata[g]),
            .rx_valid   (rvld[g]),
            .rx_ready   (rdy[g]),
            .framing_err(ferr[g]),
            .parity_err (perr[g]),
            .overrun    (ovr[g]),
            .busy       (busy[g])
        );
        initial forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (rvld[g] && rdy[g]) begin
                    total++;
                    if (dq[g].size() == 0) begin
                        bad++;
                        $display("FAIL accept u%0d: word %h delivered, expected none", g, rdata[g]);
                    end else begin
                        e = dq[g].pop_front();
                        if (rdata[g] !== e[DB-1:0]) begin
                            bad++;
                            $display("FAIL accept u%0d: word=%h expected=%h", g, rdata[g], e[DB-1:0]);
                        end
                    end
                end
                if (ferr[g]) chk_err(g, K_FERR, "framing");
                if (perr[g]) chk_err(g, K_PERR, "parity");
                if (ovr[g])  chk_err(g, K_OVR,  "overrun");
            end
        end
    end

    // Outcome of a frame from the line contents alone.
    function automatic int model(int u, bit flip, bit stopb);
        if (!stopb) return K_FERR;
        if (u != 0 && flip) return K_PERR;
        return 0;
    endfunction

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Start bits fall just before an edge 2 clk ahead of a tick, so rx_s lands on a tick.
    task automatic align(output int e);
        do @(negedge clk); while ((cyc + 1) % 4 != 2);
        e = cyc + 1;
    endtask

    task automatic send(int u, int word, bit flip, bit stopb, int nbits);
        bit b[$];
        bit pb;
        b.push_back(1'b0);
        for (int i = 0; i < DB; i++) b.push_back(word[i]);
        if (u != 0) begin
            pb = (u == 1) ? ^word[DB-1:0] : ~^word[DB-1:0];
            b.push_back(pb ^ flip);
        end
        b.push_back(stopb);
        for (int i = 0; i < b.size() && i < nbits; i++) begin
            rx[u] = b[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic frame(int u, int word, bit flip, bit stopb, bit ovr_exp, bit pulse_rdy);
        int e, s, k;
        logic [2:0] exp_p;
        k = model(u, flip, stopb);
        if (k == 0 && ovr_exp) k = K_OVR;
        if (k == 0) dq[u].push_back(word & 'hFF);
        else        eq[u].push_back(k);
        exp_p = (k == K_FERR) ? 3'b100 : (k == K_PERR) ? 3'b010 : (k == K_OVR) ? 3'b001 : 3'b000;
        align(e);
        // Stop bit is line position DB+1(+1 with parity), sampled 10 clk into a 16-clk bit.
        s = e + 10 + 16 * (DB + 1 + ((u != 0) ? 1 : 0));
        fork
            send(u, word, flip, stopb, 99);
            begin
                wait_cyc(s - 1);
                check("busy_before_stop", {31'd0, busy[u]}, 32'd1);
                if (pulse_rdy) rdy[u] = 1'b1;
                @(negedge clk);
                check("pulses", {29'd0, ferr[u], perr[u], ovr[u]}, {29'd0, exp_p});
                check("busy_after_stop", {31'd0, busy[u]}, (k == K_FERR) ? 32'd1 : 32'd0);
                if (k == 0) check("deliver", {23'd0, rvld[u], rdata[u]}, {23'd0, 1'b1, word[DB-1:0]});
                if (pulse_rdy) rdy[u] = 1'b0;
                if (k == 0 && rdy[u]) begin
                    @(negedge clk);
                    check("valid_one_clk", {31'd0, rvld[u]}, 32'd0);
                end
            end
        join
    endtask

    task automatic chk_idle_outputs(int u, string nm);
        check(nm, {21'd0, rvld[u], rdata[u], ferr[u], perr[u], ovr[u], busy[u]}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, u, w;
        bit fl, sb;
        for (int i = 0; i < 3; i++) begin
            rx[i]  = 1'b1;
            rdy[i] = 1'b1;
        end
        rst = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle_outputs(i, "reset_state");
        rst = 1'b0;
        repeat (8) @(negedge clk);

        frame(0, 'hA5, 0, 1, 0, 0);
        repeat (20) @(negedge clk);

        // Start glitch one tick period wide.
        align(e);
        rx[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx[0] = 1'b1;
        wait_cyc(e + 6);
        check("glitch_busy", {31'd0, busy[0]}, 32'd1);
        wait_cyc(e + 10);
        check("glitch_idle", {31'd0, busy[0]}, 32'd0);
        repeat (40) @(negedge clk);

        // Framing error followed by a 3-bit-time break.
        frame(0, 'h3C, 0, 0, 0, 0);
        repeat (48) @(negedge clk);
        check("break_held", {31'd0, busy[0]}, 32'd1);
        rx[0] = 1'b1;
        repeat (32) @(negedge clk);
        frame(0, 'h81, 0, 1, 0, 0);

        frame(1, 'h07, 0, 1, 0, 0);
        frame(1, 'h07, 1, 1, 0, 0);
        frame(2, 'h07, 0, 1, 0, 0);
        frame(2, 'h07, 1, 1, 0, 0);

        // Overrun: consumer stalled across two back-to-back frames.
        rdy[0] = 1'b0;
        frame(0, 'h11, 0, 1, 0, 0);
        frame(0, 'h22, 0, 1, 1, 0);
        check("overrun_hold", {23'd0, rvld[0], rdata[0]}, {23'd0, 1'b1, 8'h11});
        rdy[0] = 1'b1;
        @(negedge clk);
        check("overrun_drain", {31'd0, rvld[0]}, 32'd0);

        // Accept and delivery on the same edge.
        rdy[0] = 1'b0;
        frame(0, 'h44, 0, 1, 0, 0);
        frame(0, 'h55, 0, 1, 0, 1);
        rdy[0] = 1'b1;
        repeat (4) @(negedge clk);

        // Reset partway through a frame.
        align(e);
        send(0, 'hF0, 0, 1, 4);
        check("rst_midframe_busy", {31'd0, busy[0]}, 32'd1);
        rx[0] = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        chk_idle_outputs(0, "rst_midframe");
        repeat (40) @(negedge clk);
        frame(0, 'h9A, 0, 1, 0, 0);

        repeat (24) begin
            u  = $urandom_range(0, 2);
            w  = $urandom_range(0, 255);
            fl = (u != 0) && ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 5) != 0);
            frame(u, w, fl, sb, 0, 0);
            if (!sb) begin
                repeat ($urandom_range(0, 48)) @(negedge clk);
                rx[u] = 1'b1;
                repeat (24) @(negedge clk);
            end
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("data_queue_empty", dq[i].size(), 32'd0);
            check("err_queue_empty", eq[i].size(), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
